// File: rtl/gpio_cfg_sequencer.sv
// gpio_cfg_sequencer
//   Master-side sequencer for the pad-ring GPIO configuration chain. On a load
//   request it snapshots the flattened per-pad config vector and shifts it
//   MSB-first into the chain. It then pulses serial_load and raises done for one
//   cycle. Bits returned from the chain tail are captured as readback.
//   With AUTO_START set, one load of DEFAULT_CFG (replicated to every pad) runs
//   automatically on the first cycle after reset release.
//
// Ports
//   mclk            core clock
//   resetn          asynchronous active-low reset
//   start           load request, sampled only while idle
//   cfg_data        pad k config at [k*CTRL_BITS +: CTRL_BITS]
//   busy            high while a sequence is shifting or loading
//   done            one-cycle pulse when a sequence completes
//   rdbk_data       bits captured from serial_data_in, stable while !busy
//   serial_clock    chain shift clock (registered)
//   serial_load     chain load strobe (registered)
//   serial_data_out chain data into pad 0 (registered)
//   serial_data_in  chain data returned from the last pad
module gpio_cfg_sequencer #(
  parameter int                   NUM_PADS    = 15,
  parameter int                   CTRL_BITS   = 12,
  parameter int                   CLK_DIV     = 4,
  parameter logic [CTRL_BITS-1:0] DEFAULT_CFG = 'hC00,
  parameter bit                   AUTO_START  = 1'b1
) (
  input  logic                            mclk,
  input  logic                            resetn,
  input  logic                            start,
  input  logic [NUM_PADS*CTRL_BITS-1:0]   cfg_data,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_PADS*CTRL_BITS-1:0]   rdbk_data,
  output logic                            serial_clock,
  output logic                            serial_load,
  output logic                            serial_data_out,
  input  logic                            serial_data_in
);

  localparam int TOTAL = NUM_PADS * CTRL_BITS;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(TOTAL + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [TOTAL-1:0] rdbk_q, rdbk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             load_q, load_d;
  logic             sdo_q, sdo_d;
  logic             auto_pend_q, auto_pend_d;

  logic [TOTAL-1:0] next_shadow;
  logic [TOTAL-1:0] shadow_shl;

  assign shadow_shl = shadow_q << 1;

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shadow_d    = shadow_q;
    rdbk_d      = rdbk_q;
    busy_d      = busy_q;
    done_d      = done_q;
    sclk_d      = sclk_q;
    load_d      = load_q;
    sdo_d       = sdo_q;
    auto_pend_d = auto_pend_q;
    next_shadow = auto_pend_q ? {NUM_PADS{DEFAULT_CFG}} : cfg_data;

    case (state_q)
      ST_IDLE: begin
        // The pending auto-load only gets one chance: the first idle cycle.
        auto_pend_d = 1'b0;
        if (auto_pend_q || start) begin
          shadow_d  = next_shadow;
          sdo_d     = next_shadow[TOTAL-1];
          sclk_d    = 1'b0;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            // Capture on the edge that raises serial_clock; the newest
            // sample enters at the LSB.
            sclk_d = 1'b1;
            rdbk_d = TOTAL'({rdbk_q, serial_data_in});
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              load_d  = 1'b1;
              state_d = ST_LOAD;
            end else begin
              // Data advances only as serial_clock falls.
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              shadow_d  = shadow_shl;
              sdo_d     = shadow_shl[TOTAL-1];
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_LOAD: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          load_d    = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_DONE;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_DONE: begin
        // start is not looked at here; it is accepted from the next idle cycle.
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shadow_q    <= '0;
      rdbk_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sclk_q      <= 1'b0;
      load_q      <= 1'b0;
      sdo_q       <= 1'b0;
      auto_pend_q <= AUTO_START;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shadow_q    <= shadow_d;
      rdbk_q      <= rdbk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sclk_q      <= sclk_d;
      load_q      <= load_d;
      sdo_q       <= sdo_d;
      auto_pend_q <= auto_pend_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign rdbk_data       = rdbk_q;
  assign serial_clock    = sclk_q;
  assign serial_load     = load_q;
  assign serial_data_out = sdo_q;

endmodule
